// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: counter encodings, default size, PC width.
package branch_predictor_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned DEF_ENTRIES = 16;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function used by the BTB training path.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i && ctr_i != ST) begin
            ctr_o = ctr_i + 2'd1;
        end else if (!taken_i && ctr_i != SNT) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF-stage lookup, EX-stage training,
// same-cycle mispredict/redirect and branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispredict_cnt_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ctr_d;

    // Lookup returns pre-update contents; there is no write-to-read bypass.
    always_comb begin
        if_idx      = if_pc[IDX_W+1:2];
        if_tag      = if_pc[31:IDX_W+2];
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    always_comb begin
        ex_idx      = ex_pc[IDX_W+1:2];
        ex_tag      = ex_pc[31:IDX_W+2];
        ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
        redirect_pc = (mispredict && ex_taken) ? ex_target : ex_pc + 32'd4;
    end

    sat_counter2 u_ctr (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (ex_taken),
        .ctr_o   (ctr_d)
    );

    // Training: hits move the counter, taken misses allocate weak-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (ex_valid) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_d;
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= WT;
            end
            branch_cnt_q     <= branch_cnt_q + 32'd1;
            mispredict_cnt_q <= mispredict_cnt_q + 32'(mispredict);
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// against a table-of-records reference model.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;

    // Reference model: one record per slot, counter kept as a plain 0..3 integer.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int s = slot_of(pc);
        return m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic m_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit mp);
        int s = slot_of(pc);
        if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
            if (tk) begin
                m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = tgt;
            end else begin
                m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (tk) begin
            m_valid[s] = 1'b1;
            m_tag[s]   = tag_of(pc);
            m_tgt[s]   = tgt;
            m_ctr[s]   = 2;
        end
        m_bcnt = m_bcnt + 1;
        m_mcnt = m_mcnt + (mp ? 1 : 0);
    endtask

    // One cycle: drive at negedge, check outputs against the model, train after posedge.
    task automatic step(input bit v, input logic [31:0] ipc, input logic [31:0] epc,
                        input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        bit mp;
        if_pc = ipc; ex_valid = v; ex_pc = epc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        #1;
        mp = v && ((tk != ptk) || (tk && ptk && tgt != ptgt));
        chk("pred_taken",  32'(pred_taken), 32'(m_pred(ipc)));
        chk("pred_target", pred_target, m_pred_tgt(ipc));
        chk("mispredict",  32'(mispredict), 32'(mp));
        chk("redirect_pc", redirect_pc, (mp && tk) ? tgt : epc + 32'd4);
        chk("branch_cnt",  branch_cnt, m_bcnt);
        chk("mispred_cnt", mispredict_cnt, m_mcnt);
        @(posedge clk);
        if (v) m_train(epc, tk, tgt, mp);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] ipc);
        step(1'b0, ipc, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, b, t, pt;
        bit          tk, ptk;

        rst_n = 1'b0; if_pc = 32'h00400010; ex_valid = 1'b0; ex_pc = '0;
        ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        m_reset();
        #12 rst_n = 1'b1;
        @(negedge clk);

        // Post-reset lookup
        #1;
        chk("rst_pred_taken",  32'(pred_taken), 32'h0);
        chk("rst_pred_target", pred_target, 32'h00400014);
        chk("rst_branch_cnt",  branch_cnt, 32'h0);
        chk("rst_mispred_cnt", mispredict_cnt, 32'h0);

        // First taken branch
        if_pc = 32'h00400010; ex_valid = 1'b1; ex_pc = 32'h00400010; ex_taken = 1'b1;
        ex_target = 32'h00400040; ex_pred_taken = 1'b0; ex_pred_target = 32'h00400014;
        #1;
        chk("first_mispredict", 32'(mispredict), 32'h1);
        chk("first_redirect",   redirect_pc, 32'h00400040);
        step(1'b1, 32'h00400010, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h00400014);
        #1;
        chk("first_trained_taken", 32'(pred_taken), 32'h1);
        chk("first_trained_tgt",   pred_target, 32'h00400040);
        chk("first_mispred_cnt",   mispredict_cnt, 32'h1);

        // Hysteresis
        step(1'b1, 32'h00400010, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040);
        step(1'b1, 32'h00400010, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040);
        step(1'b1, 32'h00400010, 32'h00400010, 1'b0, 32'h00400040, 1'b1, 32'h00400040);
        #1 chk("hyst_one_nt", 32'(pred_taken), 32'h1);
        step(1'b1, 32'h00400010, 32'h00400010, 1'b0, 32'h00400040, 1'b1, 32'h00400040);
        #1;
        chk("hyst_two_nt",     32'(pred_taken), 32'h0);
        chk("hyst_two_nt_tgt", pred_target, 32'h00400014);

        // Re-train, then alias into slot 4 with a different tag
        step(1'b1, 32'h00400050, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h00400014);
        look(32'h00400050);
        step(1'b1, 32'h00400050, 32'h00400050, 1'b1, 32'h00400080, 1'b0, 32'h00400054);
        #1 chk("alias_new_hit", pred_target, 32'h00400080);
        look(32'h00400010);
        #1 chk("alias_old_miss", pred_target, 32'h00400014);

        // Correct prediction, target mismatch, not-taken mispredict
        step(1'b1, 32'h00400020, 32'h00400020, 1'b1, 32'h00400040, 1'b1, 32'h00400040);
        step(1'b1, 32'h00400020, 32'h00400020, 1'b1, 32'h00400040, 1'b1, 32'h00400044);
        ex_valid = 1'b1; ex_pc = 32'h00400030; ex_taken = 1'b0; ex_pred_taken = 1'b1;
        #1;
        chk("nt_mispredict", 32'(mispredict), 32'h1);
        chk("nt_redirect",   redirect_pc, 32'h00400034);
        step(1'b1, 32'h00400030, 32'h00400030, 1'b0, 32'h00400100, 1'b1, 32'h00400100);

        // Same-cycle collision: lookup sees old entry, new entry next cycle
        step(1'b1, 32'h00400060, 32'h00400060, 1'b1, 32'h00400200, 1'b0, 32'h00400064);
        look(32'h00400060);

        // Reset asserted in the middle of an ex_valid cycle
        if_pc = 32'h00400050; ex_valid = 1'b1; ex_pc = 32'h00400050; ex_taken = 1'b1;
        ex_target = 32'h00400300; ex_pred_taken = 1'b1; ex_pred_target = 32'h00400080;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        foreach (m_valid[i]) begin
            if_pc = 32'h00400000 + 32'(i * 4);
            #1 chk("rst_mid_miss", 32'(pred_taken), 32'h0);
        end
        chk("rst_mid_bcnt", branch_cnt, 32'h0);
        chk("rst_mid_mcnt", mispredict_cnt, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
        m_reset();
        look(32'h00400050);
        look(32'h00400060);

        // Random traffic over a small PC pool to exercise hits, aliases and saturation
        for (int n = 0; n < 400; n++) begin
            a   = 32'h00400000 + 32'($urandom_range(0, 31) * 4);
            b   = 32'h00400000 + 32'($urandom_range(0, 31) * 4);
            if ($urandom_range(0, 15) == 0) b = $urandom & 32'hFFFF_FFFC;
            tk  = 1'($urandom_range(0, 2) != 0);
            t   = 32'h00400000 + 32'($urandom_range(0, 3) * 64);
            ptk = m_pred(b);
            pt  = m_pred_tgt(b);
            if ($urandom_range(0, 5) == 0) begin
                ptk = 1'($urandom);
                pt  = t ^ (32'($urandom_range(0, 1)) << 6);
            end
            step(1'($urandom_range(0, 3) != 0), a, b, tk, t, ptk, pt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage MIPS core, and the consumer of the EX-stage branch comparator result.
- At IF it looks up the fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and supplies a predicted next PC.
- At EX it takes the resolved outcome (comparator condition or jump), trains the table, and raises a same-cycle mispredict/redirect to the flush logic.
- It also keeps branch and mispredict statistics counters.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of two, minimum 4.
- IDX_W, log2(ENTRIES): index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  fetch-stage PC (word aligned).
- pred_taken  out  1  prediction for if_pc.
- pred_target  out  32  predicted next PC.
- ex_valid  in  1  a branch/jump is resolving in EX this cycle.
- ex_pc  in  32  PC of the resolving instruction.
- ex_taken  in  1  resolved direction (comparator condition result; 1 for jumps).
- ex_target  in  32  resolved taken target.
- ex_pred_taken  in  1  prediction carried down the pipeline with this instruction.
- ex_pred_target  in  32  predicted target carried down the pipeline.
- mispredict  out  1  flush request.
- redirect_pc  out  32  correct next PC on mispredict.
- branch_cnt  out  32  resolved branches since reset.
- mispredict_cnt  out  32  mispredicts since reset.

## Operation
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Counter encoding: 00 strong not-taken, 01 weak NT, 10 weak T, 11 strong T.
- Lookup (combinational):
  - hit = valid & (tag == if_pc tag).
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4.
- Update, on the clock edge when ex_valid=1:
  - Hit: ctr increments (saturating at 11) if ex_taken, otherwise decrements (saturating at 00). If ex_taken, target <= ex_target.
  - Miss and ex_taken: allocate or replace the entry with valid=1, the new tag, target=ex_target, ctr=10.
  - Miss and not taken: no write.
- mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target))).
- redirect_pc = ex_taken ? ex_target : ex_pc+4. Don't-care when mispredict=0; it is driven to ex_pc+4 in that case.
- Counters, on the clock edge when ex_valid=1:
  - branch_cnt += 1.
  - mispredict_cnt += mispredict.
  - Both wrap modulo 2^32.
- Address arithmetic is 32-bit; +4 wraps with no overflow flag.

## Timing
- Lookup: zero-cycle combinational from if_pc.
- Training: visible to lookups from the cycle after the ex_valid edge.
- Same-cycle read/write to the same index: the lookup returns the pre-update contents. There is no bypass.
- mispredict/redirect_pc: combinational in the ex_valid cycle. Flush happens at the following edge.
- Reset (asynchronous, any time, including mid-update):
  - All valid <= 0, ctr <= 01; tags and targets are don't-care.
  - branch_cnt and mispredict_cnt <= 0.
  - While rst_n=0, no update occurs even if ex_valid=1.
- Outputs during and after reset:
  - pred_taken=0 and pred_target=if_pc+4.
  - mispredict follows its equation. The pipeline holds ex_valid low during reset.
- Stalls are handled upstream. ex_valid must be high for exactly one cycle per resolved instruction.

## Structure
- Shared package:
  - Counter encoding constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Default ENTRIES.
  - PC width 32.
- Sub-module sat_counter2: pure next-state function (ctr, taken -> ctr_next). One instance, in the update path.
- Storage: register arrays (ENTRIES is small) with an asynchronous read port and one synchronous write port.

## Test plan
All scenarios use ENTRIES=16.
- Post-reset lookup: if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014; branch_cnt=0, mispredict_cnt=0.
- First taken branch: ex_valid=1, ex_pc=0x00400010, ex_taken=1, ex_target=0x00400040, ex_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x00400040.
  - Next cycle, if_pc=0x00400010: pred_taken=1, pred_target=0x00400040.
  - mispredict_cnt=1.
- Hysteresis on 0x00400010:
  - Two more taken resolutions -> ctr=11.
  - One not-taken -> still predicts taken (ctr=10).
  - Second not-taken -> pred_taken=0, pred_target=0x00400014.
- Aliasing: 0x00400050 has the same index (4) as 0x00400010 but a different tag.
  - Lookup misses.
  - A taken resolution to 0x00400080 replaces the entry; 0x00400010 then misses.
- Correct prediction and target mismatch:
  - ex_taken=1, ex_pred_taken=1, equal targets -> mispredict=0.
  - Same with ex_pred_target=0x00400044 vs ex_target=0x00400040 -> mispredict=1, redirect_pc=0x00400040.
  - Not-taken mispredict -> redirect_pc=ex_pc+4.
- Same-cycle collision and reset:
  - Update and lookup to the same index in one cycle -> lookup shows the old entry, the new entry appears next cycle.
  - Asserting rst_n=0 in the middle of an ex_valid cycle -> no write, all lookups miss, counters read 0.
